// File: rtl/tactile_frame_packer_if.sv
// Valid/ready packet stream carrying frame headers and magnitude words
// from the frame packer toward the USB/serial link.
interface tactile_frame_packer_if #(
    parameter int MAG_BITS = 16
) ();
    logic                pkt_valid;
    logic                pkt_ready;
    logic [MAG_BITS-1:0] pkt_data;
    logic                pkt_last;

    modport master (output pkt_valid, output pkt_data, output pkt_last, input pkt_ready);
    modport slave  (input pkt_valid, input pkt_data, input pkt_last, output pkt_ready);
endinterface

// File: rtl/tactile_frame_packer.sv
// Folds I/Q readout pairs into saturated magnitudes, fills a double-buffered
// frame RAM and streams each completed frame as a headered packet.
module tactile_frame_packer #(
    parameter int DAC_CHANNELS = 16,
    parameter int ADC_CHANNELS = 16,
    parameter int IN_BITS      = 32,
    parameter int MAG_BITS     = 16,
    parameter int MAG_SHIFT    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid_i,
    input  logic [$clog2(DAC_CHANNELS)-1:0] in_dac_i,
    input  logic [$clog2(ADC_CHANNELS)-1:0] in_adc_i,
    input  logic                            in_phase_i,
    input  logic [IN_BITS-1:0]              in_data_i,
    tactile_frame_packer_if.master          pkt,
    output logic                            frame_drop_o,
    output logic                            frame_err_o,
    output logic [15:0]                     drop_count_o
);
    localparam int DW    = $clog2(DAC_CHANNELS);
    localparam int AW    = $clog2(ADC_CHANNELS);
    localparam int CW    = DW + AW;
    localparam int KW    = CW + 1;
    localparam int SUM_W = IN_BITS + 1;
    localparam int NCELL = DAC_CHANNELS * ADC_CHANNELS;
    localparam logic [KW-1:0] LAST_K    = KW'(2 * NCELL - 1);
    localparam logic [CW-1:0] LAST_CELL = CW'(NCELL - 1);

    typedef enum logic {WR_WAIT_START, WR_FILL} wrState_e;
    typedef enum logic [1:0] {RD_IDLE, RD_HEADER, RD_CELLS} rdState_e;

    wrState_e            wrState_q, wrState_d;
    rdState_e            rdState_q, rdState_d;
    logic [KW-1:0]       expK_q, expK_d;
    logic [IN_BITS-1:0]  iLatch_q;
    logic                wrEn_q, wrLast_q, frameDone_q, wrBank_q;
    logic [CW-1:0]       wrAddr_q, cellIdx_q, rdAddr;
    logic [MAG_BITS-1:0] wrData_q, ramQ_q, mag;
    logic [7:0]          seq_q, hdrSeq_q;
    logic                frameDrop_q, frameErr_q;
    logic [15:0]         dropCount_q;
    logic [MAG_BITS-1:0] cellRam [0:2*NCELL-1];
    logic [KW-1:0]       inK;
    logic                latchI, cellWr, lastCell, orderErr, handoff, dropEv, fire;
    logic [SUM_W-1:0]    absI, absQ, magSum, magShift;

    // Channel indices are powers of two, so the sequence index is a plain concatenation.
    assign inK = {in_adc_i, in_dac_i, in_phase_i};

    // |I|+|Q| is formed one bit wider than the input so that |-2^(N-1)| does not wrap.
    always_comb begin
        absI     = iLatch_q[IN_BITS-1] ? (SUM_W'(0) - {iLatch_q[IN_BITS-1], iLatch_q})
                                       : {1'b0, iLatch_q};
        absQ     = in_data_i[IN_BITS-1] ? (SUM_W'(0) - {in_data_i[IN_BITS-1], in_data_i})
                                        : {1'b0, in_data_i};
        magSum   = absI + absQ;
        magShift = magSum >> MAG_SHIFT;
        mag      = (|magShift[SUM_W-1:MAG_BITS]) ? '1 : magShift[MAG_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrState_q <= WR_WAIT_START;
            rdState_q <= RD_IDLE;
        end else begin
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
        end
    end

    always_comb begin
        wrState_d = wrState_q;
        case (wrState_q)
            WR_WAIT_START: if (latchI) wrState_d = WR_FILL;
            WR_FILL:       if ((orderErr && !latchI) || lastCell) wrState_d = WR_WAIT_START;
            default:       wrState_d = WR_WAIT_START;
        endcase
    end

    // A mismatched k=0 word is still an order error but immediately seeds a new fill.
    always_comb begin
        latchI   = 1'b0;
        cellWr   = 1'b0;
        lastCell = 1'b0;
        orderErr = 1'b0;
        expK_d   = expK_q;
        if (in_valid_i) begin
            case (wrState_q)
                WR_WAIT_START: begin
                    if (inK == '0) begin
                        latchI = 1'b1;
                        expK_d = KW'(1);
                    end
                end
                WR_FILL: begin
                    if (inK != expK_q) begin
                        orderErr = 1'b1;
                        if (inK == '0) begin
                            latchI = 1'b1;
                            expK_d = KW'(1);
                        end
                    end else begin
                        expK_d = expK_q + KW'(1);
                        if (!in_phase_i) begin
                            latchI = 1'b1;
                        end else begin
                            cellWr   = 1'b1;
                            lastCell = (inK == LAST_K);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expK_q      <= '0;
            iLatch_q    <= '0;
            wrEn_q      <= 1'b0;
            wrLast_q    <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            expK_q      <= expK_d;
            wrEn_q      <= cellWr;
            wrLast_q    <= lastCell;
            frameDone_q <= wrEn_q && wrLast_q;
            frameErr_q  <= orderErr;
            if (latchI) iLatch_q <= in_data_i;
            if (cellWr) begin
                wrAddr_q <= {in_adc_i, in_dac_i};
                wrData_q <= mag;
            end
        end
    end

    // A frame finishing while any packet is still in flight (even its final cycle) is dropped.
    assign handoff = frameDone_q && (rdState_q == RD_IDLE);
    assign dropEv  = frameDone_q && (rdState_q != RD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrBank_q    <= 1'b0;
            seq_q       <= '0;
            hdrSeq_q    <= '0;
            frameDrop_q <= 1'b0;
            dropCount_q <= '0;
        end else begin
            frameDrop_q <= dropEv;
            if (handoff) begin
                wrBank_q <= ~wrBank_q;
                hdrSeq_q <= seq_q;
                seq_q    <= seq_q + 8'd1;
            end
            if (dropEv && dropCount_q != 16'hFFFF) dropCount_q <= dropCount_q + 16'd1;
        end
    end

    assign fire = (rdState_q != RD_IDLE) && pkt.pkt_ready;

    always_comb begin
        rdState_d = rdState_q;
        case (rdState_q)
            RD_IDLE:   if (handoff) rdState_d = RD_HEADER;
            RD_HEADER: if (fire) rdState_d = RD_CELLS;
            RD_CELLS:  if (fire && cellIdx_q == LAST_CELL) rdState_d = RD_IDLE;
            default:   rdState_d = RD_IDLE;
        endcase
    end

    always_comb begin
        pkt.pkt_valid = 1'b0;
        pkt.pkt_data  = '0;
        pkt.pkt_last  = 1'b0;
        case (rdState_q)
            RD_HEADER: begin
                pkt.pkt_valid = 1'b1;
                pkt.pkt_data  = MAG_BITS'({8'hA5, hdrSeq_q});
            end
            RD_CELLS: begin
                pkt.pkt_valid = 1'b1;
                pkt.pkt_data  = ramQ_q;
                pkt.pkt_last  = (cellIdx_q == LAST_CELL);
            end
            default: ;
        endcase
    end

    // Prefetch the next cell on each handshake so the registered read port never bubbles.
    always_comb begin
        rdAddr = '0;
        if (rdState_q == RD_CELLS) rdAddr = fire ? cellIdx_q + CW'(1) : cellIdx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cellIdx_q <= '0;
        end else if (rdState_q == RD_HEADER) begin
            cellIdx_q <= '0;
        end else if (rdState_q == RD_CELLS && fire) begin
            cellIdx_q <= cellIdx_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn_q) cellRam[{wrBank_q, wrAddr_q}] <= wrData_q;
        ramQ_q <= cellRam[{~wrBank_q, rdAddr}];
    end

    assign frame_drop_o = frameDrop_q;
    assign frame_err_o  = frameErr_q;
    assign drop_count_o = dropCount_q;
endmodule
